// File: rtl/carry_lookahead_adder.sv
// ---------------------------------------------------------------------------
// carry_lookahead_adder
//
// Registered WIDTH-bit unsigned adder: {Cout, Sum} <= A + B + Cin.
// The carries come from two levels of carry look-ahead. The first level works
// inside each 4-bit group. The second level is a flattened look-ahead across
// the group generate/propagate terms. No carry ripples through the group
// adders. Results appear one clock after the operands are sampled.
//
// Parameters:
//   WIDTH  operand/sum width, a multiple of 4 in the range 4..64
//   GROUP  bits per look-ahead group, fixed at 4
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, clears Sum/Cout (and Ovf)
//   A, B   unsigned operands
//   Cin    carry-in
//   Sum    registered (A+B+Cin) mod 2^WIDTH
//   Cout   registered carry out of the MSB
//   Ovf    registered signed overflow; present only when CLA_OVERFLOW_EN is
//          defined
//
// Optional feature macro: CLA_OVERFLOW_EN
// ---------------------------------------------------------------------------
module carry_lookahead_adder #(
    parameter int WIDTH = 4,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef CLA_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    localparam int NG = WIDTH / 4;

    if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("carry_lookahead_adder: WIDTH must be a multiple of 4 in 4..64");
    end
    if (GROUP != 4) begin : g_bad_group
        $error("carry_lookahead_adder: GROUP is fixed at 4");
    end

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;

    assign g = A & B;
    assign p = A ^ B;

    // First level: carries inside each 4-bit group, plus the group G/P terms.
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        localparam int B0 = gi * 4;

        assign c[B0]     = grp_c[gi];
        assign c[B0 + 1] = g[B0]
                         | (p[B0] & grp_c[gi]);
        assign c[B0 + 2] = g[B0 + 1]
                         | (p[B0 + 1] & g[B0])
                         | (p[B0 + 1] & p[B0] & grp_c[gi]);
        assign c[B0 + 3] = g[B0 + 2]
                         | (p[B0 + 2] & g[B0 + 1])
                         | (p[B0 + 2] & p[B0 + 1] & g[B0])
                         | (p[B0 + 2] & p[B0 + 1] & p[B0] & grp_c[gi]);

        assign grp_g[gi] = g[B0 + 3]
                         | (p[B0 + 3] & g[B0 + 2])
                         | (p[B0 + 3] & p[B0 + 2] & g[B0 + 1])
                         | (p[B0 + 3] & p[B0 + 2] & p[B0 + 1] & g[B0]);
        assign grp_p[gi] = &p[B0 +: 4];
    end

    // Second level: each group carry is a flat OR of product terms,
    // G[j] & P[j+1..k] for every j <= k, plus Cin & P[0..k]. It never
    // depends on the carry from the group below it.
    logic term_cin;
    logic term_g;
    logic acc;

    always_comb begin
        grp_c    = '0;
        term_cin = 1'b0;
        term_g   = 1'b0;
        acc      = 1'b0;
        grp_c[0] = Cin;
        for (int k = 0; k < NG; k++) begin
            term_cin = Cin;
            for (int m = 0; m <= k; m++) begin
                term_cin = term_cin & grp_p[m];
            end
            acc = term_cin;
            for (int j = 0; j <= k; j++) begin
                term_g = grp_g[j];
                for (int m = j + 1; m <= k; m++) begin
                    term_g = term_g & grp_p[m];
                end
                acc = acc | term_g;
            end
            grp_c[k + 1] = acc;
        end
    end

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;

    assign sum_d  = p ^ c;
    assign cout_d = grp_c[NG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;

`ifdef CLA_OVERFLOW_EN
    logic ovf_d, ovf_q;

    // Signed overflow: the carry into the MSB differs from the carry out of it.
    assign ovf_d = c[WIDTH-1] ^ grp_c[NG];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// ---------------------------------------------------------------------------
// tb_carry_lookahead_adder
//
// Drives a 4-bit and a 16-bit adder from the same clock. Each cycle the bench
// computes the expected results from its own arithmetic model and pushes them
// to a scoreboard queue. One cycle later it pops them and compares them with
// the registered outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_carry_lookahead_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  a4, b4;
    logic        cin4;
    logic [3:0]  sum4;
    logic        cout4;
    logic [15:0] a16, b16;
    logic        cin16;
    logic [15:0] sum16;
    logic        cout16;
`ifdef CLA_OVERFLOW_EN
    logic        ovf4, ovf16;
`endif

    always #5 clk = ~clk;

    carry_lookahead_adder #(.WIDTH(4)) u_dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (a4),
        .B    (b4),
        .Cin  (cin4),
        .Sum  (sum4),
        .Cout (cout4)
`ifdef CLA_OVERFLOW_EN
        ,
        .Ovf  (ovf4)
`endif
    );

    carry_lookahead_adder #(.WIDTH(16)) u_dut16 (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (a16),
        .B    (b16),
        .Cin  (cin16),
        .Sum  (sum16),
        .Cout (cout16)
`ifdef CLA_OVERFLOW_EN
        ,
        .Ovf  (ovf16)
`endif
    );

    typedef struct {
        logic [4:0]  r4;
        logic [16:0] r16;
        logic        ovf4;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives one set of operands and queues the expected result. It then
    // waits one edge and compares the popped expectation with the outputs.
    task automatic step(input logic rst, input logic [3:0] a, input logic [3:0] b,
                        input logic ci, input logic [15:0] x, input logic [15:0] y,
                        input logic cx, input string tag);
        exp_t e;
        int   s;
        rst_n = rst;
        a4 = a;  b4 = b;  cin4 = ci;
        a16 = x; b16 = y; cin16 = cx;
        s = $signed({{28{a[3]}}, a}) + $signed({{28{b[3]}}, b}) + int'(ci);
        if (rst) begin
            e.r4   = {1'b0, a} + {1'b0, b} + {4'b0, ci};
            e.r16  = {1'b0, x} + {1'b0, y} + {16'b0, cx};
            e.ovf4 = (s > 7) || (s < -8);
        end else begin
            e.r4   = '0;
            e.r16  = '0;
            e.ovf4 = 1'b0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_w4"},  {59'd0, cout4, sum4},   {59'd0, e.r4});
            check({tag, "_w16"}, {47'd0, cout16, sum16}, {47'd0, e.r16});
`ifdef CLA_OVERFLOW_EN
            check({tag, "_ovf"}, {63'd0, ovf4}, {63'd0, e.ovf4});
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0;

        // Reset holds the outputs at zero even with all-ones operands.
        step(1'b0, 4'hF, 4'hF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "rst0");
        step(1'b0, 4'hF, 4'hF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "rst1");
        // The first edge after release registers the current operands.
        step(1'b1, 4'hF, 4'hF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "rel");

        // Exhaustive 4-bit sweep with Cin=0; the 16-bit adder gets random data.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ab;
            ab = 8'(i);
            step(1'b1, ab[7:4], ab[3:0], 1'b0,
                 16'($urandom), 16'($urandom), 1'($urandom), "sweep");
        end

        // Directed boundary cases.
        step(1'b1, 4'h9, 4'h8, 1'b0, 16'hFFFF, 16'h0001, 1'b0, "a9b8_xgrp");
        step(1'b1, 4'hF, 4'h0, 1'b1, 16'h0FFF, 16'h0001, 1'b0, "prop_grp");
        step(1'b1, 4'h7, 4'h0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, "c_in7_p16");
        step(1'b1, 4'h8, 4'h8, 1'b0, 16'h8000, 16'h8000, 1'b0, "gen");
        step(1'b1, 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0, "zero");
        step(1'b1, 4'h7, 4'h1, 1'b0, 16'h00FF, 16'hFF01, 1'b0, "ovf_pos");
        step(1'b1, 4'hF, 4'h1, 1'b0, 16'hF0F0, 16'h0F10, 1'b0, "noovf");
        step(1'b1, 4'h8, 4'hF, 1'b1, 16'h7FFF, 16'h0000, 1'b1, "neg_edge");

        // Random mixed Cin.
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 4'($urandom), 4'($urandom), 1'($urandom),
                 16'($urandom), 16'($urandom), 1'($urandom), "rand");
        end

        // Reset asserted mid-stream clears everything, Ovf included.
        step(1'b1, 4'h7, 4'h1, 1'b0, 16'hFFFF, 16'h0001, 1'b0, "pre_rst");
        step(1'b0, 4'h7, 4'h1, 1'b0, 16'hFFFF, 16'h0001, 1'b0, "mid_rst");
        step(1'b1, 4'h3, 4'h4, 1'b1, 16'h1234, 16'h4321, 1'b1, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/carry_lookahead_adder.md
Name: carry_lookahead_adder

Overview:
- WIDTH-bit unsigned adder with carry-in, built from two-level carry look-ahead logic (no ripple chain).
- Sum and carry-out are registered, so the block drops into a single-clock datapath as a 1-cycle arithmetic stage.
- Default configuration is a 4-bit adder: A + B + Cin -> {Cout, Sum}.

Parameters:
- WIDTH, 4, operand and sum width.
  - Legal values: multiples of 4 from 4 to 64.
  - Any other value is a compile-time error (generate-time $error).
- GROUP, 4, bits per look-ahead group. Fixed at 4; exposed for documentation only. WIDTH/GROUP groups.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- Cin  input  1  carry-in
- Sum  output  WIDTH  registered (A+B+Cin) mod 2^WIDTH
- Cout  output  1  registered carry out of MSB

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset:
  - rst_n sampled low at a rising clk edge -> Sum=0, Cout=0 on that edge.
  - Reset has priority over the add result.
  - No asynchronous clear.
- Bit level: g[i]=A[i]&B[i]; p[i]=A[i]^B[i].
- Group level, per 4-bit group k with group carry-in c0:
  - c1=g0|p0c0
  - c2=g1|p1g0|p1p0c0
  - c3=g2|p2g1|p2p1g0|p2p1p0c0
  - Group G=g3|p3g2|p3p2g1|p3p2p1g0
  - Group P=p3&p2&p1&p0
- Second level:
  - Group carries come from flattened look-ahead over the group G/P, with Cin as carry into group 0.
  - No carry may propagate through a chain of group adders.
- Sum[i]=p[i]^c[i]. Cout = carry out of the last group.
- Latency:
  - Operands and Cin presented before edge N appear on Sum/Cout after edge N (1 cycle).
  - Throughput is one add per cycle; no handshake and no stall.
- Width rules:
  - {Cout,Sum} is exactly A+B+Cin as an unsigned (WIDTH+1)-bit value.
  - Wrap-around past 2^WIDTH-1 is reported only via Cout.
- Inputs are sampled only at clk edges; X/glitch on inputs between edges has no effect on outputs.
- Reset deasserted mid-stream: the first edge with rst_n high registers the current operands; no stale data is kept.
- Power-up before the first reset edge is undefined. Benches must apply reset first.

Optional Feature:
- Macro: CLA_OVERFLOW_EN.
- Defined:
  - Adds output port Ovf (1 bit, registered): signed two's-complement overflow.
  - Ovf = carry into MSB XOR carry out of MSB.
  - Same 1-cycle latency as Sum; reset value 0.
- Not defined: port Ovf does not exist and no overflow logic is built.

Test Plan:
- Reset: rst_n=0, A=4'hF, B=4'hF, Cin=1 for 2 edges -> Sum=0, Cout=0. Release rst_n -> next edge Sum=4'hF, Cout=1.
- Exhaustive 4-bit, Cin=0: {A,B} swept 0..255, one per cycle -> each result one cycle later equals A+B.
  - Example: A=9, B=8 -> Sum=1, Cout=1.
- Cin=1 carry chain: A=4'hF, B=4'h0, Cin=1 -> Sum=0, Cout=1 (full propagate path). A=4'h7, B=4'h0, Cin=1 -> Sum=8, Cout=0.
- Generate path: A=4'h8, B=4'h8, Cin=0 -> Sum=0, Cout=1. A=0, B=0, Cin=0 -> Sum=0, Cout=0.
- WIDTH=16: A=16'hFFFF, B=16'h0001, Cin=0 -> Sum=0, Cout=1 (cross-group look-ahead). A=16'h0FFF, B=16'h0001 -> Sum=16'h1000, Cout=0.
- With CLA_OVERFLOW_EN, WIDTH=4: A=7, B=1 -> Sum=8, Ovf=1. A=4'h8, B=4'h8 -> Ovf=1. A=4'hF, B=1 -> Ovf=0. Reset -> Ovf=0.
